// File: rtl/lt_pkg.sv
// Shared types and byte constants for the level-translator serial command path.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package lt_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_BANK,
        ST_ARG,
        ST_RESP_WAIT,
        ST_RESP_SEND
    } state_t;

    localparam logic [7:0] SYNC_BYTE  = 8'hA5;
    localparam logic [7:0] CMD_WRITE  = 8'h01;
    localparam logic [7:0] CMD_OE     = 8'h02;
    localparam logic [7:0] CMD_STROBE = 8'h03;
    localparam logic [7:0] RESP_ACK   = 8'h06;
    localparam logic [7:0] RESP_NAK   = 8'h15;

endpackage

// File: rtl/lt_pulse_gen.sv
// Retriggerable fixed-width pulse: WIDTH cycles high after the last trig.
// Latency: pulse rises the cycle after trig.
// Backpressure: none; a trig while active reloads the count with no low gap.
module lt_pulse_gen #(
    parameter int WIDTH = 50
) (
    input  logic clk,
    input  logic rst_n,
    input  logic trig,
    output logic pulse
);

    localparam int CW = ($clog2(WIDTH) > 0) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [CW-1:0] cnt;

    // Count remaining high cycles; the cycle with cnt==0 is the last high one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt   <= '0;
            pulse <= 1'b0;
        end else if (trig) begin
            cnt   <= CNT_LAST;
            pulse <= 1'b1;
        end else if (pulse) begin
            if (cnt == '0) begin
                pulse <= 1'b0;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/lt_serial_driver.sv
// Parses A5-framed command bytes and drives 64 translator pins, OEs and a strobe.
// Latency: register update the cycle after the argument byte; response two cycles after the frame end at the earliest.
// Backpressure: response is held in RESP_WAIT while tx_busy; bytes arriving then are dropped.
module lt_serial_driver
    import lt_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 5000000,
    parameter int STROBE_CYCLES  = 50
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        new_rx_data,
    output logic [7:0]  tx_data,
    output logic        new_tx_data,
    input  logic        tx_busy,
    output logic [63:0] data_out,
    output logic [63:0] data_oe,
    output logic        strobe,
    output logic        busy
);

    localparam int TW = ($clog2(TIMEOUT_CYCLES) > 0) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_t        state;
    logic          cmd_is_oe;
    logic [2:0]    bank;
    logic [7:0]    resp;
    logic [TW-1:0] to_cnt;
    logic          frame_active;
    logic          to_expired;
    logic          strobe_trig;

    assign frame_active = (state == ST_CMD) || (state == ST_BANK) || (state == ST_ARG);
    assign to_expired   = frame_active && (to_cnt == TO_LAST);
    assign strobe_trig  = (state == ST_CMD) && new_rx_data && (rx_data == CMD_STROBE);
    assign busy         = (state != ST_IDLE);

    // Inter-byte watchdog: runs only mid-frame, any received byte restarts it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else if (new_rx_data || !frame_active) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    // Frame parser, bank registers and one-shot response handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cmd_is_oe   <= 1'b0;
            bank        <= '0;
            resp        <= '0;
            data_out    <= '0;
            data_oe     <= '0;
            tx_data     <= '0;
            new_tx_data <= 1'b0;
        end else begin
            new_tx_data <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (new_rx_data && (rx_data == SYNC_BYTE)) begin
                        state <= ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (new_rx_data) begin
                        if ((rx_data == CMD_WRITE) || (rx_data == CMD_OE)) begin
                            cmd_is_oe <= (rx_data == CMD_OE);
                            state     <= ST_BANK;
                        end else if (rx_data == CMD_STROBE) begin
                            resp  <= RESP_ACK;
                            state <= ST_RESP_WAIT;
                        end else begin
                            resp  <= RESP_NAK;
                            state <= ST_RESP_WAIT;
                        end
                    end else if (to_expired) begin
                        state <= ST_IDLE;
                    end
                end
                ST_BANK: begin
                    if (new_rx_data) begin
                        if (rx_data <= 8'd7) begin
                            bank  <= rx_data[2:0];
                            state <= ST_ARG;
                        end else begin
                            resp  <= RESP_NAK;
                            state <= ST_RESP_WAIT;
                        end
                    end else if (to_expired) begin
                        state <= ST_IDLE;
                    end
                end
                ST_ARG: begin
                    if (new_rx_data) begin
                        if (cmd_is_oe) begin
                            data_oe[{bank, 3'b000} +: 8] <= rx_data;
                        end else begin
                            data_out[{bank, 3'b000} +: 8] <= rx_data;
                        end
                        resp  <= RESP_ACK;
                        state <= ST_RESP_WAIT;
                    end else if (to_expired) begin
                        state <= ST_IDLE;
                    end
                end
                ST_RESP_WAIT: begin
                    if (!tx_busy) begin
                        tx_data     <= resp;
                        new_tx_data <= 1'b1;
                        state       <= ST_RESP_SEND;
                    end
                end
                ST_RESP_SEND: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    lt_pulse_gen #(
        .WIDTH (STROBE_CYCLES)
    ) u_strobe (
        .clk   (clk),
        .rst_n (rst_n),
        .trig  (strobe_trig),
        .pulse (strobe)
    );

endmodule

// File: tb/tb_lt_serial_driver.sv
// Directed bench for lt_serial_driver with hand-computed expectations.
// Latency: n/a.
// Backpressure: exercises tx_busy stalls on the response path.
module tb_lt_serial_driver;

    logic        clk;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        new_rx_data;
    logic [7:0]  tx_data;
    logic        new_tx_data;
    logic        tx_busy;
    logic [63:0] data_out;
    logic [63:0] data_oe;
    logic        strobe;
    logic        busy;

    int n_cmp;
    int n_err;
    int tx_cnt;
    logic [7:0] tx_last;
    int dbl_cnt;
    logic prev_ntx;

    lt_serial_driver #(
        .TIMEOUT_CYCLES (100),
        .STROBE_CYCLES  (50)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_data     (rx_data),
        .new_rx_data (new_rx_data),
        .tx_data     (tx_data),
        .new_tx_data (new_tx_data),
        .tx_busy     (tx_busy),
        .data_out    (data_out),
        .data_oe     (data_oe),
        .strobe      (strobe),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Response monitor, sampled 2 time units after each rising edge.
    initial begin
        tx_cnt   = 0;
        tx_last  = 8'h00;
        dbl_cnt  = 0;
        prev_ntx = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (new_tx_data) begin
                tx_cnt  = tx_cnt + 1;
                tx_last = tx_data;
                if (prev_ntx) dbl_cnt = dbl_cnt + 1;
            end
            prev_ntx = new_tx_data;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp = n_cmp + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the byte is taken.
    task automatic send_byte(input logic [7:0] b);
        rx_data     = b;
        new_rx_data = 1'b1;
        @(negedge clk);
        new_rx_data = 1'b0;
    endtask

    task automatic wait_resp(input string tag, input logic [7:0] exp);
        for (int i = 0; i < 60; i++) begin
            if (tx_cnt > 0) break;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        check({tag, "_count"}, 64'(tx_cnt), 64'd1);
        check({tag, "_byte"}, 64'(tx_last), 64'(exp));
        check({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int hi;
        int low_gap;
        n_cmp       = 0;
        n_err       = 0;
        rst_n       = 1'b0;
        rx_data     = 8'h00;
        new_rx_data = 1'b0;
        tx_busy     = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_data_out", data_out, 64'd0);
        check("rst_data_oe", data_oe, 64'd0);
        check("rst_strobe", 64'(strobe), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_new_tx", 64'(new_tx_data), 64'd0);
        check("rst_tx_data", 64'(tx_data), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Write bank 3
        tx_cnt = 0;
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h03); send_byte(8'h5A);
        check("wr_data_out", data_out, 64'h0000_0000_5A00_0000);
        wait_resp("wr_ack", 8'h06);

        // OE bank 7 with the transmitter busy
        tx_cnt  = 0;
        tx_busy = 1'b1;
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h07); send_byte(8'hF0);
        check("oe_data_oe", data_oe, 64'hF000_0000_0000_0000);
        repeat (20) @(negedge clk);
        check("oe_held_while_busy", 64'(tx_cnt), 64'd0);
        check("oe_busy_state", 64'(busy), 64'd1);
        tx_busy = 1'b0;
        wait_resp("oe_ack", 8'h06);

        // Bad bank
        tx_cnt = 0;
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h09);
        wait_resp("badbank_nak", 8'h15);
        check("badbank_data_out", data_out, 64'h0000_0000_5A00_0000);
        check("badbank_data_oe", data_oe, 64'hF000_0000_0000_0000);

        // Bad command
        tx_cnt = 0;
        send_byte(8'hA5); send_byte(8'h7E);
        wait_resp("badcmd_nak", 8'h15);

        // Leading junk
        tx_cnt = 0;
        send_byte(8'h00); send_byte(8'hFF);
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'h11);
        check("junk_data_out", data_out, 64'h0000_0000_5A00_0011);
        wait_resp("junk_ack", 8'h06);

        // Single strobe: high on 50 consecutive sample points
        tx_cnt = 0;
        send_byte(8'hA5); send_byte(8'h03);
        hi = 0;
        while (strobe && hi < 200) begin
            hi = hi + 1;
            @(negedge clk);
        end
        check("strobe_width", 64'(hi), 64'd50);
        check("strobe_ack_count", 64'(tx_cnt), 64'd1);
        check("strobe_ack_byte", 64'(tx_last), 64'h06);

        // Retrigger 30 cycles after the first CMD byte
        tx_cnt = 0;
        send_byte(8'hA5); send_byte(8'h03);
        low_gap = 0;
        for (int i = 0; i < 28; i++) begin
            if (!strobe) low_gap = low_gap + 1;
            @(negedge clk);
        end
        send_byte(8'hA5);
        if (!strobe) low_gap = low_gap + 1;
        send_byte(8'h03);
        hi = 0;
        while (strobe && hi < 200) begin
            hi = hi + 1;
            @(negedge clk);
        end
        check("retrig_no_gap", 64'(low_gap), 64'd0);
        check("retrig_tail", 64'(hi), 64'd50);
        check("retrig_ack_count", 64'(tx_cnt), 64'd2);

        // Timeout after A5 01
        tx_cnt = 0;
        send_byte(8'hA5); send_byte(8'h01);
        repeat (90) @(negedge clk);
        check("to_still_busy", 64'(busy), 64'd1);
        repeat (15) @(negedge clk);
        check("to_idle", 64'(busy), 64'd0);
        check("to_no_resp", 64'(tx_cnt), 64'd0);
        check("to_no_update", data_out, 64'h0000_0000_5A00_0011);
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'h22);
        check("to_after_data", data_out, 64'h0000_0000_5A00_0022);
        wait_resp("to_after_ack", 8'h06);

        // Reset in ARG while strobe is active
        tx_cnt = 0;
        send_byte(8'hA5); send_byte(8'h03);
        wait_resp("prerst_ack", 8'h06);
        tx_cnt = 0;
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h02);
        check("prerst_strobe", 64'(strobe), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mrst_data_out", data_out, 64'd0);
        check("mrst_data_oe", data_oe, 64'd0);
        check("mrst_strobe", 64'(strobe), 64'd0);
        check("mrst_busy", 64'(busy), 64'd0);
        send_byte(8'h33);
        repeat (10) @(negedge clk);
        check("mrst_arg_dropped", data_out, 64'd0);
        check("mrst_no_resp", 64'(tx_cnt), 64'd0);
        check("mrst_strobe_off", 64'(strobe), 64'd0);

        check("no_back_to_back_tx", 64'(dbl_cnt), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/lt_serial_driver.md
Name: lt_serial_driver

Overview:
- Reverse direction of the trigger-sampling byte path: parses framed command bytes arriving from the AVR serial link and drives the 64 level-translator data pins.
- Per-bank output data, per-bit output enables and a timed strobe pulse.
- Answers every complete frame with one ACK/NAK byte through the AVR interface tx handshake.
- Sits between avr_interface (rx_data/new_rx_data, tx_data/new_tx_data/tx_busy) and the top-level pin tri-state logic.

Parameters:
- TIMEOUT_CYCLES, 5000000, max clk cycles allowed between bytes of one frame (100 ms at 50 MHz).
- STROBE_CYCLES, 50, strobe high time in clk cycles (1 us at 50 MHz); must be >= 1.

Ports:
- clk  input  1  50 MHz system clock
- rst_n  input  1  synchronous active-low reset
- rx_data  input  8  received byte from avr_interface
- new_rx_data  input  1  one-cycle valid for rx_data
- tx_data  output  8  response byte to avr_interface
- new_tx_data  output  1  one-cycle send request for tx_data
- tx_busy  input  1  avr_interface transmitter busy
- data_out  output  64  pin output values, bank b = bits [8b+7:8b]
- data_oe  output  64  per-pin output enable, 1 = drive
- strobe  output  1  active-high timed pulse
- busy  output  1  high whenever state != IDLE

Behaviour:
- Reset: synchronous, sampled on posedge clk while rst_n=0; overrides everything, including mid-frame, mid-response and an active strobe.
- Reset values: data_out=0, data_oe=0 (all pins input, safe), strobe=0, tx_data=0, new_tx_data=0, busy=0, state=IDLE.
- Frame format: SYNC 0xA5, CMD, then arguments:
  - CMD 0x01 WRITE: BANK, DATA.
  - CMD 0x02 OE: BANK, MASK.
  - CMD 0x03 STROBE: no arguments.
- States: IDLE, CMD, BANK, ARG, RESP_WAIT, RESP_SEND.
- IDLE: wait for a byte. 0xA5 -> CMD; any other byte is discarded silently.
- CMD:
  - 0x01/0x02 -> BANK.
  - 0x03 -> load strobe counter, resp=ACK, go to RESP_WAIT.
  - Any other value -> resp=NAK, go to RESP_WAIT.
- BANK: byte <= 7 -> latch bank, go to ARG. Byte > 7 -> resp=NAK, go to RESP_WAIT. In the NAK case the argument byte is not consumed.
- ARG:
  - WRITE: data_out[8*bank+:8] <= byte.
  - OE: data_oe[8*bank+:8] <= byte.
  - Both commands: resp=ACK, go to RESP_WAIT.
  - The update is visible on the cycle after the new_rx_data that carried the byte.
- RESP_WAIT: when tx_busy=0, drive tx_data=resp (ACK 0x06, NAK 0x15) and pulse new_tx_data for exactly one cycle, then go to RESP_SEND.
- RESP_SEND: one cycle, then IDLE. new_tx_data is never high on two consecutive cycles.
- Bytes arriving in RESP_WAIT/RESP_SEND are dropped. Host protocol: wait for the response before sending the next frame.
- Timeout:
  - Counter clears on every new_rx_data and increments in CMD/BANK/ARG.
  - Reaching TIMEOUT_CYCLES-1 -> IDLE with no response and no register update.
  - Counter is inactive in IDLE and the RESP states.
- Strobe:
  - STROBE_CYCLES-cycle down-counter, independent of the FSM.
  - strobe=1 starting the cycle after the CMD byte, for exactly STROBE_CYCLES cycles.
  - A re-trigger while active reloads the counter; the pulse extends with no low gap.
- Simultaneous events: new_rx_data and a timeout expiry on the same cycle -> the byte wins and the counter clears.
- Widths: counters are sized with $clog2 of their parameter; bank index is 3 bits.

Decomposition:
- Shared package lt_pkg holds:
  - state enum;
  - constants SYNC_BYTE=0xA5, CMD_WRITE=0x01, CMD_OE=0x02, CMD_STROBE=0x03, RESP_ACK=0x06, RESP_NAK=0x15.
- One natural sub-module: lt_pulse_gen (retriggerable fixed-width pulse, parameter WIDTH, inputs clk/rst_n/trig, output pulse), instantiated for strobe.
- FSM, bank registers and the response path stay in lt_serial_driver.

Test Plan:
- Write: send A5 01 03 5A -> data_out[31:24]=0x5A and all other bits 0; one new_tx_data pulse with tx_data=0x06.
- Output enable with busy transmitter: send A5 02 07 F0 while tx_busy=1 for 20 cycles -> data_oe[63:56]=0xF0 immediately; new_tx_data stays 0 until tx_busy falls, then one pulse with 0x06.
- Errors: bad bank A5 01 09 -> NAK 0x15 and no register change. Bad command A5 7E -> NAK 0x15. Leading junk 00 FF before A5 01 00 11 -> ignored; data_out[7:0]=0x11 and ACK.
- Strobe: send A5 03 -> strobe high for exactly 50 cycles and ACK. A second A5 03 at cycle 30 -> strobe stays high until 50 cycles after the second CMD byte.
- Timeout: with TIMEOUT_CYCLES=100, send A5 01 then idle 100 cycles -> busy falls, no response byte. Following A5 01 00 22 -> ACK, data_out[7:0]=0x22.
- Reset mid-operation: assert rst_n=0 for 1 cycle in ARG while strobe is active -> all outputs return to 0 on the next cycle, state=IDLE, no response is emitted.
